// File: rtl/fifo_pkg.sv
// Shared definitions for the FIFO read-side streaming block: state encodings
// and default widths.
package fifo_pkg;
  localparam int DEF_WIDTH = 8;
  localparam int DEF_CNT_W = 16;

  // Skid-buffer occupancy states: 0, 1 or 2 words held.
  typedef enum logic [1:0] {
    S_EMPTY = 2'd0,
    S_ONE   = 2'd1,
    S_TWO   = 2'd2
  } state_t;
endpackage

// File: rtl/skid_buf2.sv
// Two-entry skid storage. r_head is always the oldest word; r_tail is only
// meaningful when two words are held.
module skid_buf2
  import fifo_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_push,
  input  logic             i_pop,
  input  state_t           i_state,
  input  logic [WIDTH-1:0] i_data,
  output logic [WIDTH-1:0] o_head
);
  logic [WIDTH-1:0] r_head;
  logic [WIDTH-1:0] r_tail;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_head <= '0;
      r_tail <= '0;
    end else begin
      case (i_state)
        S_EMPTY: begin
          if (i_push) r_head <= i_data;
        end
        S_ONE: begin
          if (i_push && i_pop)  r_head <= i_data;
          else if (i_push)      r_tail <= i_data;
        end
        S_TWO: begin
          // A push is only granted here together with a pop.
          if (i_pop) r_head <= r_tail;
          if (i_push && i_pop) r_tail <= i_data;
        end
        default: begin
          r_head <= r_head;
        end
      endcase
    end
  end

  assign o_head = r_head;
endmodule

// File: rtl/fifo_rd_stream.sv
// Drains a show-ahead FIFO into a registered valid/ready stream through a
// two-entry skid buffer, counting every delivered word.
module fifo_rd_stream
  import fifo_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int CNT_W = DEF_CNT_W
) (
  input  logic             R_CLK,
  input  logic             R_RST,
  input  logic             EMPTY,
  input  logic [WIDTH-1:0] RD_DATA,
  output logic             R_INC,
  input  logic             FLUSH,
  output logic [WIDTH-1:0] OUT_DATA,
  output logic             OUT_VALID,
  input  logic             OUT_READY,
  output logic [CNT_W-1:0] OUT_COUNT,
  output state_t           o_dbg_state
);
  // Stream handshake: a word transfers on every rising edge where
  // OUT_VALID and OUT_READY are both 1; OUT_DATA is held while stalled.
  state_t           r_state;
  state_t           w_next;
  logic             r_valid;
  logic [CNT_W-1:0] r_count;
  logic             w_push;
  logic             w_pop;

  always_ff @(posedge R_CLK) begin
    if (R_RST) begin
      r_state <= S_EMPTY;
      r_valid <= 1'b0;
    end else begin
      r_state <= w_next;
      r_valid <= (w_next != S_EMPTY);
    end
  end

  always_comb begin
    w_next = r_state;
    if (FLUSH) begin
      w_next = S_EMPTY;
    end else begin
      case (r_state)
        S_EMPTY: if (w_push) w_next = S_ONE;
        S_ONE: begin
          if (w_push && !w_pop)      w_next = S_TWO;
          else if (!w_push && w_pop) w_next = S_EMPTY;
        end
        S_TWO:   if (w_pop && !w_push) w_next = S_ONE;
        default: w_next = S_EMPTY;
      endcase
    end
  end

  always_comb begin
    w_pop  = r_valid & OUT_READY;
    w_push = ~EMPTY & ~FLUSH & ~R_RST & ((r_state != S_TWO) | w_pop);
  end

  // A transfer accepted during FLUSH still counts.
  always_ff @(posedge R_CLK) begin
    if (R_RST) r_count <= '0;
    else if (w_pop) r_count <= r_count + {{(CNT_W-1){1'b0}}, 1'b1};
  end

  skid_buf2 #(.WIDTH(WIDTH)) u_skid (
    .i_clk   (R_CLK),
    .i_rst   (R_RST),
    .i_push  (w_push),
    .i_pop   (w_pop),
    .i_state (r_state),
    .i_data  (RD_DATA),
    .o_head  (OUT_DATA)
  );

  assign R_INC       = w_push;
  assign OUT_VALID   = r_valid;
  assign OUT_COUNT   = r_count;
  assign o_dbg_state = r_state;
endmodule
